fetch_branch_predictor: RTL and testbench

- Fetch-stage predictor that consumes execute-stage branch resolution (PCsrc, taken/target) and produces next-PC predictions.
- Direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating counters (00 NT | 01 NT | 10 T | 11 T).
- Lookup is combinational on the fetch PC; training and mispredict detection run on the resolution port.
- Mispredict and redirect are registered and drive the fetch flush and PC mux.

---
 rtl/fetch_branch_predictor.sv | 138 +++++++++++++
 tb/tb_fetch_branch_predictor.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit counters, registered mispredict/redirect.
// Optional statistics counters are enabled by defining PRED_STATS_EN.
module fetch_branch_predictor #(
    parameter int          XLEN     = 32,
    parameter int          IDX_W    = 4,
    parameter int          TAG_W    = XLEN - IDX_W - 2,
    parameter logic [1:0]  CTR_INIT = 2'b01
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] fetchPC,
    output logic            predTaken,
    output logic [XLEN-1:0] predNextPC,
    input  logic            resValid,
    input  logic [XLEN-1:0] resPC,
    input  logic            resTaken,
    input  logic [XLEN-1:0] resTarget,
    input  logic            resPredTaken,
    input  logic [XLEN-1:0] resPredTarget,
    output logic            mispredict,
    output logic [XLEN-1:0] redirectPC,
    output logic [31:0]     branchCount,
    output logic [31:0]     mispredictCount
);

    localparam int ENTRIES = 2 ** IDX_W;

    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];
    logic [XLEN-1:0]  target_d [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [1:0]       ctr_d    [ENTRIES];

    logic             mispredict_q, mispredict_d;
    logic [XLEN-1:0]  redirect_q, redirect_d;

    logic [IDX_W-1:0] fetch_idx, res_idx;
    logic [TAG_W-1:0] fetch_tag, res_tag;
    logic             fetch_hit, res_hit, res_err;

    assign fetch_idx = fetchPC[IDX_W+1:2];
    assign fetch_tag = fetchPC[XLEN-1:IDX_W+2];
    assign res_idx   = resPC[IDX_W+1:2];
    assign res_tag   = resPC[XLEN-1:IDX_W+2];

    // Lookup reads the registered table, so a same-cycle update is not visible yet.
    always_comb begin
        fetch_hit  = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
        predTaken  = fetch_hit && ctr_q[fetch_idx][1];
        predNextPC = predTaken ? target_q[fetch_idx] : fetchPC + XLEN'(4);
    end

    always_comb begin
        valid_d      = valid_q;
        tag_d        = tag_q;
        target_d     = target_q;
        ctr_d        = ctr_q;
        res_hit      = valid_q[res_idx] && (tag_q[res_idx] == res_tag);
        res_err      = (resTaken != resPredTaken) ||
                       (resTaken && resPredTaken && (resTarget != resPredTarget));
        mispredict_d = resValid && res_err;
        redirect_d   = redirect_q;
        if (resValid) begin
            redirect_d = resTaken ? resTarget : resPC + XLEN'(4);
            if (res_hit) begin
                if (resTaken) begin
                    target_d[res_idx] = resTarget;
                    if (ctr_q[res_idx] != 2'b11) ctr_d[res_idx] = ctr_q[res_idx] + 2'd1;
                end else if (ctr_q[res_idx] != 2'b00) begin
                    ctr_d[res_idx] = ctr_q[res_idx] - 2'd1;
                end
            end else if (resTaken) begin
                valid_d[res_idx]  = 1'b1;
                tag_d[res_idx]    = res_tag;
                target_d[res_idx] = resTarget;
                ctr_d[res_idx]    = 2'b10;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_INIT;
            end
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
        end else begin
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            target_q     <= target_d;
            ctr_q        <= ctr_d;
            mispredict_q <= mispredict_d;
            redirect_q   <= redirect_d;
        end
    end

    assign mispredict = mispredict_q;
    assign redirectPC = redirect_q;

`ifdef PRED_STATS_EN
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (resValid && (branch_cnt_q != 32'hFFFF_FFFF))
            branch_cnt_d = branch_cnt_q + 32'd1;
        if (mispredict_d && (mispred_cnt_q != 32'hFFFF_FFFF))
            mispred_cnt_d = mispred_cnt_q + 32'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branchCount     = branch_cnt_q;
    assign mispredictCount = mispred_cnt_q;
`else
    assign branchCount     = 32'd0;
    assign mispredictCount = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_branch_predictor.sv
// Self-checking bench for fetch_branch_predictor: directed vector table, reset corner cases, random vs model.
module tb_fetch_branch_predictor;

    logic        clock, reset;
    logic [31:0] fetchPC, predNextPC, resPC, resTarget, resPredTarget, redirectPC;
    logic        predTaken, resValid, resTaken, resPredTaken, mispredict;
    logic [31:0] branchCount, mispredictCount;

    fetch_branch_predictor dut (
        .clock(clock), .reset(reset), .fetchPC(fetchPC), .predTaken(predTaken),
        .predNextPC(predNextPC), .resValid(resValid), .resPC(resPC), .resTaken(resTaken),
        .resTarget(resTarget), .resPredTaken(resPredTaken), .resPredTarget(resPredTarget),
        .mispredict(mispredict), .redirectPC(redirectPC), .branchCount(branchCount),
        .mispredictCount(mispredictCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] fpc;
        logic        rv;
        logic [31:0] rpc;
        logic        rt;
        logic [31:0] rtgt;
        logic        rpt;
        logic [31:0] rptgt;
        logic        pt;
        logic [31:0] npc;
        logic        mis;
        logic [31:0] redir;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // Reference model: plain per-entry arrays, counter as an integer 0..3.
    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    logic [31:0] m_redir;
    longint      m_bc, m_mc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
        end
        m_redir = '0; m_bc = 0; m_mc = 0;
    endtask

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[pc[5:2]] && (m_tag[pc[5:2]] == pc[31:6]);
    endfunction

    function automatic bit m_pt(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[pc[5:2]] >= 2);
    endfunction

    function automatic logic [31:0] m_npc(input logic [31:0] pc);
        return m_pt(pc) ? m_tgt[pc[5:2]] : pc + 32'd4;
    endfunction

    function automatic logic [31:0] exp_bc();
`ifdef PRED_STATS_EN
        return (m_bc > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_bc[31:0];
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_mc();
`ifdef PRED_STATS_EN
        return (m_mc > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_mc[31:0];
`else
        return 32'd0;
`endif
    endfunction

    // Entered shortly after a rising edge; leaves 1 time unit after the next one.
    task automatic do_cycle(input vec_t v, input bit use_tbl);
        bit          e_pt, e_mis, err;
        logic [31:0] e_npc;
        int          idx;
        fetchPC = v.fpc; resValid = v.rv; resPC = v.rpc; resTaken = v.rt;
        resTarget = v.rtgt; resPredTaken = v.rpt; resPredTarget = v.rptgt;
        #2;
        e_pt  = use_tbl ? v.pt  : m_pt(v.fpc);
        e_npc = use_tbl ? v.npc : m_npc(v.fpc);
        chk("pred_taken", {31'd0, predTaken}, {31'd0, e_pt});
        chk("pred_next_pc", predNextPC, e_npc);
        err   = (v.rt != v.rpt) || (v.rt && v.rpt && v.rtgt != v.rptgt);
        e_mis = v.rv && err;
        idx   = int'(v.rpc[5:2]);
        if (v.rv) begin
            m_redir = v.rt ? v.rtgt : v.rpc + 32'd4;
            m_bc++;
            if (m_hit(v.rpc)) begin
                if (v.rt) begin
                    m_ctr[idx] = (m_ctr[idx] + 1 > 3) ? 3 : m_ctr[idx] + 1;
                    m_tgt[idx] = v.rtgt;
                end else begin
                    m_ctr[idx] = (m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1;
                end
            end else if (v.rt) begin
                m_valid[idx] = 1; m_tag[idx] = v.rpc[31:6]; m_tgt[idx] = v.rtgt; m_ctr[idx] = 2;
            end
        end
        if (e_mis) m_mc++;
        @(posedge clock); #1;
        chk("mispredict", {31'd0, mispredict}, {31'd0, use_tbl ? v.mis : e_mis});
        chk("redirect_pc", redirectPC, use_tbl ? v.redir : m_redir);
        chk("branch_count", branchCount, exp_bc());
        chk("mispredict_count", mispredictCount, exp_mc());
    endtask

    function automatic vec_t mk(input logic [31:0] fpc, input logic rv, input logic [31:0] rpc,
                                input logic rt, input logic [31:0] rtgt, input logic rpt,
                                input logic [31:0] rptgt, input logic pt, input logic [31:0] npc,
                                input logic mis, input logic [31:0] redir);
        vec_t v;
        v.fpc = fpc; v.rv = rv; v.rpc = rpc; v.rt = rt; v.rtgt = rtgt; v.rpt = rpt;
        v.rptgt = rptgt; v.pt = pt; v.npc = npc; v.mis = mis; v.redir = redir;
        return v;
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [25:0] t;
        logic [3:0]  i;
        logic [1:0]  lo;
        t  = 26'($urandom_range(1, 3));
        i  = 4'($urandom_range(0, 15));
        lo = 2'($urandom_range(0, 3));
        return {t, i, lo};
    endfunction

    vec_t tbl[18];
    vec_t v;

    initial begin
        // fpc, rv, rpc, rt, rtgt, rpt, rptgt | pt, npc, mis(next), redir(next)
        tbl[0]  = mk(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h0);
        tbl[1]  = mk(32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h0,   0, 32'h104, 1, 32'h200);
        tbl[2]  = mk(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h200, 0, 32'h200);
        tbl[3]  = mk(32'h100, 1, 32'h100, 0, 32'h0,   1, 32'h200, 1, 32'h200, 1, 32'h104);
        tbl[4]  = mk(32'h100, 1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h104);
        tbl[5]  = mk(32'h100, 1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h104);
        tbl[6]  = mk(32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h0,   0, 32'h104, 1, 32'h200);
        tbl[7]  = mk(32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h0,   0, 32'h104, 1, 32'h200);
        tbl[8]  = mk(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h200, 0, 32'h200);
        tbl[9]  = mk(32'h140, 1, 32'h140, 1, 32'h300, 0, 32'h0,   0, 32'h144, 1, 32'h300);
        tbl[10] = mk(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h300);
        tbl[11] = mk(32'h140, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h300, 0, 32'h300);
        tbl[12] = mk(32'hFFFFFFFC, 1, 32'h140, 1, 32'h380, 1, 32'h300, 0, 32'h0, 1, 32'h380);
        tbl[13] = mk(32'h140, 1, 32'h140, 1, 32'h380, 1, 32'h380, 1, 32'h380, 0, 32'h380);
        tbl[14] = mk(32'h140, 1, 32'h140, 0, 32'h0,   1, 32'h380, 1, 32'h380, 1, 32'h144);
        tbl[15] = mk(32'h140, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h380, 0, 32'h144);
        tbl[16] = mk(32'h180, 1, 32'h180, 0, 32'h0,   1, 32'h0,   0, 32'h184, 1, 32'h184);
        tbl[17] = mk(32'h140, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h380, 0, 32'h184);

        reset = 1'b0; fetchPC = 32'h100; resValid = 0; resPC = '0; resTaken = 0;
        resTarget = '0; resPredTaken = 0; resPredTarget = '0;
        model_reset();
        #12;
        chk("reset_pred_taken", {31'd0, predTaken}, 32'd0);
        chk("reset_pred_next_pc", predNextPC, 32'h104);
        chk("reset_mispredict", {31'd0, mispredict}, 32'd0);
        chk("reset_redirect_pc", redirectPC, 32'd0);
        chk("reset_branch_count", branchCount, 32'd0);
        chk("reset_mispredict_count", mispredictCount, 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 18; i++) do_cycle(tbl[i], 1'b1);

        // Statistics sequence: five resolutions, two of them erroneous.
        reset = 1'b0; #2; reset = 1'b1; model_reset();
        @(posedge clock); #1;
        do_cycle(mk(32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h0,   0, 0, 0, 0), 1'b0);
        do_cycle(mk(32'h100, 1, 32'h100, 1, 32'h200, 1, 32'h200, 0, 0, 0, 0), 1'b0);
        do_cycle(mk(32'h100, 1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0), 1'b0);
        do_cycle(mk(32'h100, 1, 32'h204, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0), 1'b0);
        do_cycle(mk(32'h100, 1, 32'h100, 1, 32'h240, 1, 32'h200, 0, 0, 0, 0), 1'b0);
`ifdef PRED_STATS_EN
        chk("stats_branch_5", branchCount, 32'd5);
        chk("stats_mispredict_2", mispredictCount, 32'd2);
`else
        chk("stats_branch_off", branchCount, 32'd0);
        chk("stats_mispredict_off", mispredictCount, 32'd0);
`endif
        chk("pre_reset_mispredict", {31'd0, mispredict}, 32'd1);
        chk("pre_reset_pred_taken", {31'd0, predTaken}, 32'd1);

        // Reset mid-cycle while a mispredict is showing and another erroneous one is being resolved.
        fetchPC = 32'h100; resValid = 1; resPC = 32'h100; resTaken = 1; resTarget = 32'h200;
        resPredTaken = 0;
        #2; reset = 1'b0; #1;
        chk("async_reset_mispredict", {31'd0, mispredict}, 32'd0);
        chk("async_reset_pred_taken", {31'd0, predTaken}, 32'd0);
        chk("async_reset_redirect", redirectPC, 32'd0);
        chk("async_reset_branch_count", branchCount, 32'd0);
        chk("async_reset_mispredict_count", mispredictCount, 32'd0);
        @(posedge clock); #1;
        chk("held_reset_mispredict", {31'd0, mispredict}, 32'd0);
        reset = 1'b1; resValid = 0; model_reset();
        @(posedge clock); #1;
        chk("post_reset_mispredict", {31'd0, mispredict}, 32'd0);
        chk("post_reset_pred_next_pc", predNextPC, 32'h104);

        // Randomized traffic over a few aliasing tags per index.
        for (int n = 0; n < 400; n++) begin
            v.rv  = ($urandom_range(0, 9) < 6);
            v.rpc = rand_pc();
            v.fpc = ($urandom_range(0, 3) == 0) ? v.rpc : rand_pc();
            v.rt  = $urandom_range(0, 1) != 0;
            v.rtgt = 32'($urandom_range(0, 15)) << 4;
            if ($urandom_range(0, 1) != 0) begin
                v.rpt   = m_pt(v.rpc);
                v.rptgt = v.rpt ? m_tgt[v.rpc[5:2]] : 32'($urandom_range(0, 15)) << 4;
            end else begin
                v.rpt   = $urandom_range(0, 1) != 0;
                v.rptgt = 32'($urandom_range(0, 15)) << 4;
            end
            v.pt = 0; v.npc = '0; v.mis = 0; v.redir = '0;
            do_cycle(v, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
